// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch prefetch stage.
//   fetch_entry_t   : one prefetch-queue entry {pc_plus, instr}
//   DEFAULT_PC_STEP : default PC increment per fetched instruction
//   occ_width()     : bits needed to hold an occupancy of 0..depth
// ----------------------------------------------------------------------------
package if_pkg;

  localparam int PKG_BIT_NUMBER  = 32;
  localparam int DEFAULT_PC_STEP = 4;

  typedef struct packed {
    logic [PKG_BIT_NUMBER-1:0] pc_plus;
    logic [PKG_BIT_NUMBER-1:0] instr;
  } fetch_entry_t;

  // Occupancy runs 0..depth inclusive, hence depth+1 codes.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_prefetch_stage_fifo.sv
// ----------------------------------------------------------------------------
// prefetch_fifo
// Synchronous FIFO of prefetch entries (first-word fall-through head).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : drop all entries; beats push and pop in the same cycle
//   push, din   : write an entry at the tail
//   pop         : retire the head entry
//   dout        : current head entry (undefined content when empty)
//   full, empty : occupancy flags
//   count       : occupancy 0..DEPTH
// Parameters: DEPTH (>= 2), entry_t (entry type, defaults to fetch_entry_t)
// ----------------------------------------------------------------------------
module prefetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = occ_width(DEPTH),
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  output entry_t        dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst || flush)
                                   !(pop && empty));

endmodule

// File: rtl/if_prefetch_stage.sv
// ----------------------------------------------------------------------------
// if_prefetch_stage
// Fetch stage with a prefetch queue. Holds fetch_pc, issues one read per
// cycle to a 1-cycle-latency instruction memory, and buffers returned words
// in a FIFO_DEPTH-entry queue so ID-stage freezes do not stall fetch.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   freeze          : downstream stall, head entry is held
//   branch_taken    : redirect; flushes queue and in-flight read
//   branch_address  : redirect target
//   imem_req/addr   : read request and address (addr = fetch_pc)
//   imem_data       : read data, valid the cycle after imem_req
//   pc, instruction : head entry (PC+PC_STEP, word); 0 when empty
//   valid           : queue non-empty
//   perf_fetched/perf_flushed/perf_stall : saturating 32-bit counters,
//                     present only when IF_PERF_COUNTERS_EN is defined
//
// Downstream handshake: an entry is offered while valid=1 and is consumed at
// the clock edge ending a cycle with valid=1, freeze=0 and branch_taken=0;
// while not consumed, pc/instruction stay stable.
//
// Parameters: BIT_NUMBER, FIFO_DEPTH (2..16), PC_STEP, RESET_PC.
// Optional feature macro: IF_PERF_COUNTERS_EN.
// ----------------------------------------------------------------------------
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int                    BIT_NUMBER = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    PC_STEP    = DEFAULT_PC_STEP,
  parameter logic [BIT_NUMBER-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [BIT_NUMBER-1:0] branch_address,
  output logic                  imem_req,
  output logic [BIT_NUMBER-1:0] imem_addr,
  input  logic [BIT_NUMBER-1:0] imem_data,
  output logic [BIT_NUMBER-1:0] pc,
  output logic [BIT_NUMBER-1:0] instruction,
  output logic                  valid
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed,
  output logic [31:0]           perf_stall
`endif
);

  localparam int CW = occ_width(FIFO_DEPTH);

  // Same layout as fetch_entry_t, sized by BIT_NUMBER.
  typedef struct packed {
    logic [BIT_NUMBER-1:0] pc_plus;
    logic [BIT_NUMBER-1:0] instr;
  } entry_t;

  logic [BIT_NUMBER-1:0] fetch_pc;
  logic                  inflight;
  logic                  pop;
  logic                  push;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  entry_t                push_entry;
  entry_t                head;
  int                    demand;

  assign pop = valid & ~freeze & ~branch_taken;

  // Reserve a slot for every word already requested; a same-cycle pop frees
  // one, which is what sustains 1 instruction/cycle at any depth.
  assign demand   = int'(count) + int'(inflight) - int'(pop);
  assign imem_req = ~rst & ~branch_taken & (demand < FIFO_DEPTH);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (branch_taken) begin
      fetch_pc <= branch_address;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) fetch_pc <= fetch_pc + BIT_NUMBER'(PC_STEP);
    end
  end

  // fetch_pc was advanced when the in-flight read issued and cannot have
  // changed since except by a branch (which kills the push), so it already
  // equals that read's address + PC_STEP.
  assign push               = inflight & ~branch_taken;
  assign push_entry.pc_plus = fetch_pc;
  assign push_entry.instr   = imem_data;

  prefetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign valid       = ~empty;
  assign pc          = valid ? head.pc_plus : '0;
  assign instruction = valid ? head.instr   : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || branch_taken)
                                  !(push && full && !pop));

`ifdef IF_PERF_COUNTERS_EN
  logic [32:0] flushed_sum;

  // A branch discards everything queued plus the read still in flight.
  assign flushed_sum = {1'b0, perf_flushed} + 33'(count) + 33'(inflight);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (branch_taken)
        perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
      if (freeze && valid && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Parametrised successor of the fetch stage. Holds the PC, issues one instruction-memory read per cycle to an external 1-cycle-latency memory port, and buffers returned instructions in a FIFO_DEPTH-entry prefetch queue. The queue decouples fetch from ID-stage freezes. Each queued instruction is presented downstream with its PC+PC_STEP value and a valid flag. Taken branches flush the queue, squash any in-flight read and redirect the PC.

Parameters:
BIT_NUMBER, 32, width of PC, addresses and instruction words
FIFO_DEPTH, 4, prefetch queue entries; legal range 2..16
PC_STEP, 4, PC increment per fetched instruction
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
freeze  in  1  downstream stall; head entry is not consumed
branch_taken  in  1  redirect request from EXE
branch_address  in  BIT_NUMBER  redirect target
imem_req  out  1  read request this cycle
imem_addr  out  BIT_NUMBER  read address (= fetch_pc)
imem_data  in  BIT_NUMBER  read data; valid the cycle after imem_req
pc  out  BIT_NUMBER  head entry PC+PC_STEP; 0 when empty
instruction  out  BIT_NUMBER  head entry instruction; 0 when empty
valid  out  1  queue non-empty

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc = RESET_PC; queue empty; inflight = 0; internal perf counters = 0.
  - pc, instruction and valid are all 0.
  - imem_req is 0 while rst is high.
  - rst overrides every other input.
- State per cycle:
  - fetch_pc register.
  - inflight flag: a request was issued last cycle and its data arrives this cycle.
  - Queue occupancy, 0..FIFO_DEPTH.
- Pop: pop = valid & ~freeze & ~branch_taken.
- Issue: imem_req = ~rst & ~branch_taken & (occupancy + inflight - pop < FIFO_DEPTH).
  - On issue: fetch_pc += PC_STEP (modulo 2^BIT_NUMBER, wraps silently) and inflight <= 1.
  - Without issue: fetch_pc holds and inflight <= 0.
- Push: when inflight=1 and branch_taken=0, {fetch address + PC_STEP, imem_data} is pushed at the end of the cycle.
  - The issue rule guarantees the queue never overflows. An assertion must flag push while full without a simultaneous pop.
- Simultaneous push and pop: occupancy is unchanged and the ordering is preserved.
- Latency:
  - Request issued in cycle N gives data in cycle N+1, pushed at the edge ending N+1, with valid=1 in cycle N+2.
  - After rst falls: first request (imem_addr=RESET_PC) in the first cycle with rst=0; first valid two cycles later.
- Throughput: sustained 1 instruction/cycle for any legal FIFO_DEPTH when freeze=0.
- Freeze:
  - Head entry and outputs hold stable.
  - Fetching continues until occupancy + inflight reaches FIFO_DEPTH, then imem_req drops.
  - The stream resumes in order the cycle freeze drops.
- branch_taken=1 in cycle B (priority over freeze, pop and push):
  - Queue cleared; in-flight data discarded; fetch_pc <= branch_address; inflight <= 0.
  - valid=0 in B+1, where the request to branch_address is issued.
  - First target instruction is valid in B+3.
  - Outputs in cycle B itself still show the old head, but nothing is consumed.
  - branch_taken on consecutive cycles: the last target wins.
- Reset mid-stream: queue and in-flight read are discarded; restart at RESET_PC.
- Empty queue: pc and instruction are forced to 0 so downstream sees a bubble.

Optional Feature:
IF_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs perf_fetched (32-bit): increments per pop.
  - Adds perf_flushed (32-bit): increments by the number of discarded entries (queue occupancy + inflight) on each branch_taken.
  - Adds perf_stall (32-bit): increments per cycle with freeze=1 and valid=1.
  - All three saturate at all-ones and are cleared by rst.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package if_pkg:
  - typedef fetch_entry_t {pc_plus, instr}, BIT_NUMBER-wide fields.
  - Constant DEFAULT_PC_STEP = 4.
  - Function clog2-based occupancy width helper.
- Sub-module prefetch_fifo:
  - Synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count.
  - flush has priority over push and pop.
  - Depth parameter equals FIFO_DEPTH.

Test Plan:
- Startup: memory word = address XOR 0xA5A5_0000, release rst at cycle 0 → imem_addr 0 in cycle 0; valid in cycle 2 with pc=4, instruction=0xA5A5_0000; then pc 8, 12, 16 on consecutive cycles.
- Freeze fill (FIFO_DEPTH=4): freeze=1 from cycle 5 for 10 cycles → outputs constant; imem_req drops once occupancy+inflight=4. After release, pops continue in order with no gap or duplicate.
- Branch with in-flight read: branch_taken=1, branch_address=0x100 in cycle 10 → valid=0 in cycle 11; imem_addr=0x100 in cycle 11; pc=0x104 valid in cycle 13; no pre-branch instruction appears after cycle 10.
- Branch during freeze with full queue → queue flushed; target fetched next cycle; freeze honoured on the first target entry.
- PC wrap: RESET_PC=0xFFFF_FFF8 → fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc outputs 0xFFFF_FFFC, 0x0, 0x4.
- IF_PERF_COUNTERS_EN defined: 20 pops, one branch flushing 3 entries, 5 frozen-valid cycles → perf_fetched=20, perf_flushed=3, perf_stall=5; rst clears all three.
